// File: rtl/sat_vector_driver.sv
// Exhaustive SAT search driver: walks vec_out through 0..2^N_IN-1, samples resp_in after SETTLE cycles per vector.
// Optional model counting via `SAT_DRV_MODEL_COUNT_EN (scan all vectors, count hits).
module sat_vector_driver #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            resp_in,
  output logic            busy,
  output logic            done,
  output logic            sat,
  output logic [N_IN-1:0] sat_vec,
  output logic [N_IN:0]   sat_count,
  output logic [1:0]      o_dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam logic [N_IN-1:0] VEC_MAX  = '1;
  localparam logic [3:0]      SETTLE_W = 4'(SETTLE);

  state_t          r_state;
  logic [3:0]      r_wcnt;
  logic [N_IN-1:0] r_vec;
  logic            r_busy;
  logic            r_done;
  logic            r_sat;
  logic [N_IN-1:0] r_sat_vec;
  logic [N_IN:0]   r_sat_count;

  // Handshake: start is a level sampled on each rising edge; it is only
  // acted on in IDLE or DONE, and ignored (not queued) while RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wcnt      <= '0;
      r_vec       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sat       <= 1'b0;
      r_sat_vec   <= '0;
      r_sat_count <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_wcnt      <= '0;
            r_vec       <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_sat       <= 1'b0;
            r_sat_vec   <= '0;
            r_sat_count <= '0;
          end
        end
        S_RUN: begin
          if (r_wcnt != SETTLE_W) begin
            r_wcnt <= r_wcnt + 4'd1;
          end else begin
`ifdef SAT_DRV_MODEL_COUNT_EN
            if (resp_in) begin
              r_sat_count <= r_sat_count + 1'b1;
              r_sat       <= 1'b1;
              if (!r_sat) r_sat_vec <= r_vec;
            end
            if (r_vec == VEC_MAX) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_vec  <= r_vec + 1'b1;
              r_wcnt <= '0;
            end
`else
            if (resp_in) begin
              r_state   <= S_DONE;
              r_sat     <= 1'b1;
              r_sat_vec <= r_vec;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
            end else if (r_vec == VEC_MAX) begin
              r_state   <= S_DONE;
              r_sat     <= 1'b0;
              r_sat_vec <= '0;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
            end else begin
              r_vec  <= r_vec + 1'b1;
              r_wcnt <= '0;
            end
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vec_out     = r_vec;
  assign busy        = r_busy;
  assign done        = r_done;
  assign sat         = r_sat;
  assign sat_vec     = r_sat_vec;
  assign o_dbg_state = r_state;
`ifdef SAT_DRV_MODEL_COUNT_EN
  assign sat_count = r_sat_count;
`else
  // Counter register exists but is never advanced; output is hard zero.
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_sat_vector_driver.sv
// Directed bench for sat_vector_driver: table of CUT functions on a 2-input instance,
// hand sequences for reset/restart, and a 3-input SETTLE=2 instance.
module tb_sat_vector_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [1:0] vec_a, svec_a, st_a;
  logic [2:0] vec_b, svec_b, cnt_a;
  logic [3:0] cnt_b;
  logic [1:0] st_b;
  logic       busy_a, done_a, sat_a, busy_b, done_b, sat_b;
  logic       resp_a, resp_b;
  int         mode_a = 2, mode_b = 2;
  int         pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic cut_f(input int mode, input logic [15:0] v);
    case (mode)
      0: cut_f = ~(v[0] & v[1]);
      1: cut_f = v[0] & v[1];
      3: cut_f = v[0] ^ v[1];
      4: cut_f = v[1] & ~v[0];
      5: cut_f = &v[2:0];
      default: cut_f = 1'b0;
    endcase
  endfunction

  assign resp_a = cut_f(mode_a, {14'b0, vec_a});
  assign resp_b = cut_f(mode_b, {13'b0, vec_b});

  sat_vector_driver #(.N_IN(2), .SETTLE(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .vec_out(vec_a), .resp_in(resp_a),
    .busy(busy_a), .done(done_a), .sat(sat_a), .sat_vec(svec_a),
    .sat_count(cnt_a), .o_dbg_state(st_a)
  );

  sat_vector_driver #(.N_IN(3), .SETTLE(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .vec_out(vec_b), .resp_in(resp_b),
    .busy(busy_b), .done(done_b), .sat(sat_b), .sat_vec(svec_b),
    .sat_count(cnt_b), .o_dbg_state(st_b)
  );

  task automatic check(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  typedef struct {
    string nm;
    int    mode;
    int    cyc;
    int    sat;
    int    svec;
    int    vout;
    int    cnt;
  } vec_t;

  // Start a search on instance A at edge E0 and follow it to done.
  task automatic run_a(input vec_t v);
    int n;
    int bad;
    mode_a = v.mode;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    check({v.nm, "_busy_e0"}, int'(busy_a), 1);
    check({v.nm, "_done_e0"}, int'(done_a), 0);
    n = 0; bad = 0;
    while (!done_a && n < 100) begin
      if (int'(vec_a) != n / 2) bad++;
      @(posedge clk); #1; n++;
    end
    check({v.nm, "_cycles"}, n, v.cyc);
    check({v.nm, "_trace"}, bad, 0);
    check({v.nm, "_sat"}, int'(sat_a), v.sat);
    check({v.nm, "_sat_vec"}, int'(svec_a), v.svec);
    check({v.nm, "_vec_out"}, int'(vec_a), v.vout);
    check({v.nm, "_count"}, int'(cnt_a), v.cnt);
    check({v.nm, "_busy_end"}, int'(busy_a), 0);
    check({v.nm, "_state"}, int'(st_a), 2);
  endtask

  task automatic run_b(input string nm, input int mode, input int cyc,
                       input int e_sat, input int e_svec, input int e_cnt);
    int n;
    int bad;
    mode_b = mode;
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0;
    n = 0; bad = 0;
    while (!done_b && n < 100) begin
      if (int'(vec_b) != n / 3) bad++;
      @(posedge clk); #1; n++;
    end
    check({nm, "_cycles"}, n, cyc);
    check({nm, "_trace"}, bad, 0);
    check({nm, "_sat"}, int'(sat_b), e_sat);
    check({nm, "_sat_vec"}, int'(svec_b), e_svec);
    check({nm, "_vec_out"}, int'(vec_b), 7);
    check({nm, "_count"}, int'(cnt_b), e_cnt);
  endtask

  vec_t tbl[5];

  initial begin
    int n;
`ifdef SAT_DRV_MODEL_COUNT_EN
    tbl[0] = '{"nand", 0, 8, 1, 0, 3, 3};
    tbl[1] = '{"and",  1, 8, 1, 3, 3, 1};
    tbl[2] = '{"xor",  3, 8, 1, 1, 3, 2};
    tbl[3] = '{"zero", 2, 8, 0, 0, 3, 0};
    tbl[4] = '{"is10", 4, 8, 1, 2, 3, 1};
`else
    tbl[0] = '{"nand", 0, 2, 1, 0, 0, 0};
    tbl[1] = '{"and",  1, 8, 1, 3, 3, 0};
    tbl[2] = '{"xor",  3, 4, 1, 1, 1, 0};
    tbl[3] = '{"zero", 2, 8, 0, 0, 3, 0};
    tbl[4] = '{"is10", 4, 6, 1, 2, 2, 0};
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_vec", int'(vec_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_sat", int'(sat_a), 0);
    check("rst_state", int'(st_a), 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 5; i++) run_a(tbl[i]);

    // Asynchronous reset mid-RUN, with a start pulse while reset is held.
    mode_a = 2;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    n = 0;
    while (vec_a != 2'd2 && n < 20) begin @(posedge clk); #1; n++; end
    check("mid_reach_10", int'(vec_a), 2);
    rst = 1'b1; #1;
    check("mid_rst_vec", int'(vec_a), 0);
    check("mid_rst_busy", int'(busy_a), 0);
    check("mid_rst_done", int'(done_a), 0);
    check("mid_rst_state", int'(st_a), 0);
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); rst = 1'b0; start_a = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ign_start_busy", int'(busy_a), 0);
    check("ign_start_state", int'(st_a), 0);
    run_a(tbl[3]);

    // Restart attempt during RUN, then an accepted start from DONE.
    mode_a = 1;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    check("rerun_vec", int'(vec_a), 2);
    check("rerun_busy", int'(busy_a), 1);
    n = 4;
    while (!done_a && n < 100) begin @(posedge clk); #1; n++; end
    check("rerun_cycles", n, 8);
    check("rerun_sat_vec", int'(svec_a), 3);
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    check("restart_done", int'(done_a), 0);
    check("restart_sat", int'(sat_a), 0);
    check("restart_sat_vec", int'(svec_a), 0);
    check("restart_vec", int'(vec_a), 0);
    check("restart_busy", int'(busy_a), 1);
    n = 0;
    while (!done_a && n < 100) begin @(posedge clk); #1; n++; end
    check("restart_cycles", n, 8);
    check("restart_sat_vec2", int'(svec_a), 3);

    // Wider instance with longer settle.
    run_b("b_zero", 2, 24, 0, 0, 0);
`ifdef SAT_DRV_MODEL_COUNT_EN
    run_b("b_and3", 5, 24, 1, 7, 1);
`else
    run_b("b_and3", 5, 24, 1, 7, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
